// File: rtl/noc_buf_pkg.sv
// Shared defaults and helpers for NoC input buffering.
package noc_buf_pkg;

   localparam int unsigned DEF_DATA_W = 64;
   localparam int unsigned DEF_DEPTH  = 4;
   localparam int unsigned DEF_NUM_VC = 2;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel circular FIFO with first-word-fall-through head.
module vc_fifo
   import noc_buf_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned CNT_W = clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [CNT_W-1:0]  count;

   // Caller qualifies push/pop; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= din;
            wptr      <= wptr + PTR_W'(1);
         end
         if (pop) rptr <= rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/input_vc_buffer.sv
// Router input port buffer: one FIFO per virtual channel, VC decode, output mux, sticky errors.
module input_vc_buffer
   import noc_buf_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned NUM_VC = DEF_NUM_VC
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_W-1:0]          di,
   input  logic                       WE,
   input  logic [clog2(NUM_VC)-1:0]   wr_vc,
   input  logic                       RE,
   input  logic [clog2(NUM_VC)-1:0]   rd_vc,
   output logic [DATA_W-1:0]          dout,
   output logic [NUM_VC-1:0]          full,
   output logic [NUM_VC-1:0]          empty,
   output logic                       err_ovf,
   output logic                       err_udf
);

   localparam int unsigned VC_W = clog2(NUM_VC);

   logic [DATA_W-1:0] head [NUM_VC];
   logic [NUM_VC-1:0] push;
   logic [NUM_VC-1:0] pop;

   // A full VC still takes a write when the same edge pops it.
   always_comb begin
      push = '0;
      pop  = '0;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
         pop[v]  = RE && (rd_vc == VC_W'(v)) && !empty[v];
         push[v] = WE && (wr_vc == VC_W'(v)) && (!full[v] || pop[v]);
      end
   end

   for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
      vc_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[g]),
         .pop   (pop[g]),
         .din   (di),
         .head  (head[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (WE && (push == '0)) err_ovf <= 1'b1;
         if (RE && empty[rd_vc]) err_udf <= 1'b1;
      end
   end

   assign dout = empty[rd_vc] ? '0 : head[rd_vc];

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed self-checking bench for input_vc_buffer (DATA_W=64, DEPTH=4, NUM_VC=2).
module tb_input_vc_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] di;
   logic        WE;
   logic        wr_vc;
   logic        RE;
   logic        rd_vc;
   logic [63:0] dout;
   logic [1:0]  full;
   logic [1:0]  empty;
   logic        err_ovf;
   logic        err_udf;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   input_vc_buffer #(
      .DATA_W (64),
      .DEPTH  (4),
      .NUM_VC (2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .di      (di),
      .WE      (WE),
      .wr_vc   (wr_vc),
      .RE      (RE),
      .rd_vc   (rd_vc),
      .dout    (dout),
      .full    (full),
      .empty   (empty),
      .err_ovf (err_ovf),
      .err_udf (err_udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      WE = 1'b0;
      RE = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic write(input logic [63:0] d, input logic v);
      WE = 1'b1; di = d; wr_vc = v; RE = 1'b0;
      tick();
      idle();
   endtask

   task automatic pop(input logic v);
      RE = 1'b1; rd_vc = v; WE = 1'b0;
      tick();
      idle();
   endtask

   logic [63:0] exp_q [4];

   initial begin
      reset = 1'b1; di = '0; WE = 1'b0; wr_vc = 1'b0; RE = 1'b0; rd_vc = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      check("rst_empty", empty, 2'b11);
      check("rst_full", full, 2'b00);
      check("rst_dout", dout, 64'h0);
      check("rst_ovf", err_ovf, 1'b0);
      check("rst_udf", err_udf, 1'b0);

      // Fill VC0, overflow, drain in order
      exp_q = '{64'h11, 64'h22, 64'h33, 64'h44};
      for (int i = 0; i < 4; i++) write(exp_q[i], 1'b0);
      check("fill_full", full, 2'b01);
      check("fill_empty", empty, 2'b10);
      write(64'h55, 1'b0);
      check("ovf_flag", err_ovf, 1'b1);
      check("ovf_full", full, 2'b01);
      rd_vc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("drain%0d", i), dout, exp_q[i]);
         pop(1'b0);
      end
      check("drain_empty", empty, 2'b11);
      check("drain_dout", dout, 64'h0);
      check("drain_udf", err_udf, 1'b0);
      check("ovf_sticky", err_ovf, 1'b1);

      // Full VC: simultaneous write + read
      do_reset();
      check("rst2_ovf", err_ovf, 1'b0);
      for (int i = 0; i < 4; i++) write(exp_q[i], 1'b0);
      WE = 1'b1; di = 64'h99; wr_vc = 1'b0; RE = 1'b1; rd_vc = 1'b0;
      tick();
      idle();
      check("wr_rd_full", full, 2'b01);
      check("wr_rd_ovf", err_ovf, 1'b0);
      exp_q = '{64'h22, 64'h33, 64'h44, 64'h99};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wr_rd_drain%0d", i), dout, exp_q[i]);
         pop(1'b0);
      end
      check("wr_rd_empty", empty, 2'b11);

      // Interleaved VCs
      write(64'hA0, 1'b1);
      write(64'hB0, 1'b0);
      rd_vc = 1'b1; #1;
      check("mux_vc1", dout, 64'hA0);
      rd_vc = 1'b0; #1;
      check("mux_vc0", dout, 64'hB0);
      pop(1'b1);
      check("pop_vc1_empty", empty, 2'b10);

      // Cross-VC independence: write VC1 while reading VC0
      WE = 1'b1; di = 64'hC1; wr_vc = 1'b1; RE = 1'b1; rd_vc = 1'b0;
      tick();
      idle();
      check("indep_empty", empty, 2'b01);
      rd_vc = 1'b1; #1;
      check("indep_dout", dout, 64'hC1);
      pop(1'b1);
      check("indep_drained", empty, 2'b11);
      check("indep_udf", err_udf, 1'b0);

      // Read of empty VC1 with write to VC1
      WE = 1'b1; di = 64'h7; wr_vc = 1'b1; RE = 1'b1; rd_vc = 1'b1;
      tick();
      idle();
      check("udf_flag", err_udf, 1'b1);
      check("udf_dout", dout, 64'h7);
      tick();
      check("udf_sticky", err_udf, 1'b1);

      // Reset beats a concurrent write
      write(64'hE0, 1'b0);
      write(64'hE1, 1'b0);
      reset = 1'b1; WE = 1'b1; di = 64'hDD; wr_vc = 1'b0;
      tick();
      reset = 1'b0; idle();
      rd_vc = 1'b0; #1;
      check("rstw_empty", empty, 2'b11);
      check("rstw_full", full, 2'b00);
      check("rstw_dout", dout, 64'h0);
      check("rstw_ovf", err_ovf, 1'b0);
      check("rstw_udf", err_udf, 1'b0);
      tick();
      check("rstw_discard", empty, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/input_vc_buffer.md
INPUT_VC_BUFFER -- requirements
Module: input_vc_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per virtual channel (VC); power of two, >= 2.
REQ-003 SHALL have parameter NUM_VC, default 2, number of VCs; power of two, >= 2.
REQ-004 SHALL have derived localparams VC_W = clog2(NUM_VC), PTR_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1).
REQ-005 SHALL have one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 di  input  DATA_W  write data (flit).
REQ-009 WE  input  1  write request.
REQ-010 wr_vc  input  VC_W  target VC of the write.
REQ-011 RE  input  1  read (pop) request.
REQ-012 rd_vc  input  VC_W  VC to read/present on dout.
REQ-013 dout  output  DATA_W  head flit of VC rd_vc.
REQ-014 full  output  NUM_VC  per-VC full flag.
REQ-015 empty  output  NUM_VC  per-VC empty flag.
REQ-016 err_ovf  output  1  sticky: write attempted to a full VC.
REQ-017 err_udf  output  1  sticky: read attempted from an empty VC.

Function
REQ-018 Each VC SHALL be an independent circular FIFO of DEPTH entries with write pointer, read pointer and CNT_W-bit occupancy count.
REQ-019 Write accepted on a rising edge iff WE=1 and full[wr_vc]=0 at that edge; di stored at that VC's write pointer; pointer increments mod DEPTH.
REQ-020 Read accepted iff RE=1 and empty[rd_vc]=0; that VC's read pointer increments mod DEPTH; no data movement.
REQ-021 dout SHALL be combinational (first-word-fall-through): storage at read pointer of rd_vc when empty[rd_vc]=0, else all zeros.
REQ-022 Latency: flit written at edge N appears on dout (rd_vc selecting it, VC previously empty) and empty deasserts in the cycle after edge N.
REQ-023 full[v]=1 iff count[v]=DEPTH; empty[v]=1 iff count[v]=0; both derived from registered counts.
REQ-024 Simultaneous accepted write and read on the same VC: both occur, count unchanged; this SHALL hold when that VC is full (read frees slot, write accepted same edge).
REQ-025 Simultaneous write and read on the same empty VC: write accepted; read ignored; err_udf set.
REQ-026 Write and read on different VCs in the same cycle SHALL be fully independent.
REQ-027 Rejected write: storage, pointers, count unchanged; err_ovf set to 1 at that edge.
REQ-028 Rejected read: state unchanged; err_udf set to 1 at that edge.
REQ-029 err_ovf/err_udf SHALL stay 1 until reset.

Reset
REQ-030 While reset=1 at an edge: all pointers and counts 0, all storage 0, empty all 1s, full all 0s, err_ovf=0, err_udf=0, dout=0.
REQ-031 Reset SHALL take priority over WE/RE in the same cycle; contents in flight are discarded.

Structure
REQ-032 Shared package noc_buf_pkg SHALL hold default DATA_W, DEPTH, NUM_VC constants and the clog2 function.
REQ-033 Per-VC FIFO SHALL be sub-module vc_fifo (params DATA_W, DEPTH; ports clk, reset, push, pop, din, head, full, empty), instantiated NUM_VC times by generate.
REQ-034 Top level SHALL hold write/read VC decode, dout mux and error flags only.

Verification (DATA_W=64, DEPTH=4, NUM_VC=2)
REQ-035 Reset then idle -> empty=2'b11, full=2'b00, dout=0, err_ovf=err_udf=0.
REQ-036 Write 0x11,0x22,0x33,0x44 to VC0 -> full=2'b01; fifth write 0x55 -> err_ovf=1, reads return 0x11..0x44 in order, then empty[0]=1.
REQ-037 VC0 full; same cycle WE(0x99,VC0)+RE(VC0) -> 0x11 popped, 0x99 accepted, full[0] stays 1; drain yields 0x22,0x33,0x44,0x99.
REQ-038 Interleave: write 0xA0 to VC1, 0xB0 to VC0; rd_vc=1 -> dout=0xA0; rd_vc=0 -> dout=0xB0; pop VC1 -> empty=2'b10.
REQ-039 RE on empty VC1 with WE to VC1 (0x7) -> err_udf=1, 0x7 on dout next cycle with rd_vc=1.
REQ-040 Two flits in VC0, assert reset one cycle with WE=1 -> next cycle empty=2'b11, dout=0, errors 0, write discarded.
